multi_channel_counter: RTL and testbench

Parametrised multi-channel event/duration counter for the DAQ timing path. It replaces the single-channel enable counter. Each channel counts clock cycles while its enable is high, in one of three modes: wrap at a programmable limit, saturate at the limit, or run-length measurement. Features per-channel clear, sticky overflow flags, and a coherent all-channel snapshot for AXI/readout logic.

---
 rtl/counter_pkg.sv | 26 ++
 rtl/counter_channel.sv | 111 +++++++++++
 rtl/multi_channel_counter.sv | 65 ++++++
 tb/tb_multi_channel_counter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types for the multi-channel event/duration counter.
package counter_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_WRAP = 2'd0,
    MODE_SAT  = 2'd1,
    MODE_RUN  = 2'd2
  } mode_t;

  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } ch_state_t;

  // The reserved encoding 3 behaves as WRAP.
  function automatic mode_t mode_decode(input logic [MODE_W-1:0] m);
    case (m)
      2'd1:    return MODE_SAT;
      2'd2:    return MODE_RUN;
      default: return MODE_WRAP;
    endcase
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: IDLE/COUNTING FSM with wrap, saturate and run-length modes.
module counter_channel
  import counter_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     enable_i,
  input  logic [MODE_W-1:0]        mode_i,
  input  logic [COUNTER_WIDTH-1:0] limit_i,
  output logic [COUNTER_WIDTH-1:0] count_o,
  output logic [COUNTER_WIDTH-1:0] run_len_o,
  output logic                     run_valid_o,
  output logic                     wrap_pulse_o,
  output logic                     overflow_o
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  ch_state_t                state_q, state_d;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic [COUNTER_WIDTH-1:0] run_len_q, run_len_d;
  logic                     run_valid_q, run_valid_d;
  logic                     wrap_q, wrap_d;
  logic                     ovf_q, ovf_d;
  logic [COUNTER_WIDTH-1:0] inc;
  mode_t                    mode_e;

  assign inc    = count_q + CNT_ONE;
  assign mode_e = mode_decode(mode_i);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    run_len_d   = run_len_q;
    run_valid_d = 1'b0;
    wrap_d      = 1'b0;
    ovf_d       = ovf_q;
    if (clr_i) begin
      state_d = IDLE;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (enable_i) begin
      state_d = COUNTING;
      unique case (mode_e)
        // A count above a lowered limit rolls over too, so WRAP never wraps implicitly.
        MODE_WRAP: begin
          if (count_q >= limit_i) begin
            count_d = '0;
            wrap_d  = 1'b1;
            ovf_d   = 1'b1;
          end else begin
            count_d = inc;
            if (inc == limit_i) ovf_d = 1'b1;
          end
        end
        MODE_SAT: begin
          if (count_q >= limit_i) begin
            ovf_d = 1'b1;
          end else begin
            count_d = inc;
            if (inc == limit_i) ovf_d = 1'b1;
          end
        end
        MODE_RUN: begin
          if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            count_d = inc;
            if (inc == CNT_MAX) ovf_d = 1'b1;
          end
        end
      endcase
    end else if (state_q == COUNTING) begin
      state_d = IDLE;
      if (mode_e == MODE_RUN) begin
        run_len_d   = count_q;
        run_valid_d = 1'b1;
        count_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      run_len_q   <= '0;
      run_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      run_len_q   <= run_len_d;
      run_valid_q <= run_valid_d;
      wrap_q      <= wrap_d;
      ovf_q       <= ovf_d;
    end
  end

  assign count_o      = count_q;
  assign run_len_o    = run_len_q;
  assign run_valid_o  = run_valid_q;
  assign wrap_pulse_o = wrap_q;
  assign overflow_o   = ovf_q;

endmodule

// File: rtl/multi_channel_counter.sv
// Multi-channel event/duration counter with mode-change clear and coherent snapshot.
module multi_channel_counter
  import counter_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CH-1:0]                 enable,
  input  logic [NUM_CH-1:0]                 clear,
  input  logic [MODE_W-1:0]                 mode,
  input  logic [COUNTER_WIDTH-1:0]          limit,
  input  logic                              snap,
  output logic [NUM_CH*COUNTER_WIDTH-1:0]   count,
  output logic [NUM_CH*COUNTER_WIDTH-1:0]   run_len,
  output logic [NUM_CH-1:0]                 run_valid,
  output logic [NUM_CH-1:0]                 wrap_pulse,
  output logic [NUM_CH-1:0]                 overflow,
  output logic [NUM_CH*COUNTER_WIDTH-1:0]   snap_count,
  output logic                              snap_valid
);

  logic [MODE_W-1:0]               mode_q;
  logic                            mode_chg;
  logic [NUM_CH*COUNTER_WIDTH-1:0] snap_count_q;
  logic                            snap_valid_q;

  assign mode_chg = (mode != mode_q);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    counter_channel #(
      .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (clear[g] | mode_chg),
      .enable_i    (enable[g]),
      .mode_i      (mode),
      .limit_i     (limit),
      .count_o     (count[g*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .run_len_o   (run_len[g*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .run_valid_o (run_valid[g]),
      .wrap_pulse_o(wrap_pulse[g]),
      .overflow_o  (overflow[g])
    );
  end

  // Captures the registered counts, i.e. the values before this edge's update.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= '0;
      snap_count_q <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      mode_q       <= mode;
      snap_valid_q <= snap;
      if (snap) snap_count_q <= count;
    end
  end

  assign snap_count = snap_count_q;
  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_multi_channel_counter.sv
// Scoreboard bench for multi_channel_counter (4 channels, 4-bit counts).
module tb_multi_channel_counter;

  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH-1:0]     enable, clear;
  logic [1:0]         mode;
  logic [W-1:0]       limit;
  logic               snap;
  logic [NCH*W-1:0]   count, run_len, snap_count;
  logic [NCH-1:0]     run_valid, wrap_pulse, overflow;
  logic               snap_valid;

  always #5 clk = ~clk;

  multi_channel_counter #(.NUM_CH(NCH), .COUNTER_WIDTH(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clear     (clear),
    .mode      (mode),
    .limit     (limit),
    .snap      (snap),
    .count     (count),
    .run_len   (run_len),
    .run_valid (run_valid),
    .wrap_pulse(wrap_pulse),
    .overflow  (overflow),
    .snap_count(snap_count),
    .snap_valid(snap_valid)
  );

  typedef enum int {S_COUNT, S_RUNLEN, S_RVALID, S_WRAP, S_OVF, S_SNAP, S_SVALID} sel_t;
  typedef struct {
    string       tag;
    sel_t        sel;
    int unsigned ch;
    int unsigned val;
  } exp_t;

  exp_t        sbq[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  function automatic int unsigned observe(sel_t sel, int unsigned ch);
    case (sel)
      S_COUNT:  return 32'(count[ch*W +: W]);
      S_RUNLEN: return 32'(run_len[ch*W +: W]);
      S_RVALID: return 32'(run_valid[ch]);
      S_WRAP:   return 32'(wrap_pulse[ch]);
      S_OVF:    return 32'(overflow[ch]);
      S_SNAP:   return 32'(snap_count[ch*W +: W]);
      default:  return 32'(snap_valid);
    endcase
  endfunction

  task automatic check_eq(string tag, int unsigned act, int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_exp(string tag, sel_t sel, int unsigned ch, int unsigned val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.ch = ch; e.val = val;
    sbq.push_back(e);
  endtask

  task automatic push_all(string tag, sel_t sel, int unsigned val);
    for (int unsigned c = 0; c < NCH; c++) push_exp(tag, sel, c, val);
  endtask

  // Expectations queued before a tick describe the outputs after that edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check_eq($sformatf("%s[%0d]", e.tag, e.ch), observe(e.sel, e.ch), e.val);
    end
  endtask

  initial begin
    rst = 1'b1; enable = '0; clear = '0; mode = 2'd0; limit = '0; snap = 1'b0;
    tick();
    push_all("rst_count", S_COUNT, 0);
    push_all("rst_ovf", S_OVF, 0);
    push_all("rst_rvalid", S_RVALID, 0);
    push_exp("rst_svalid", S_SVALID, 0, 0);
    tick();
    rst = 1'b0;

    // WRAP, limit 3
    limit = 4'd3;
    enable = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      push_exp("wrap_cnt", S_COUNT, 0, (i + 1) % 4);
      push_exp("wrap_pulse", S_WRAP, 0, ((i + 1) % 4 == 0) ? 1 : 0);
      push_exp("wrap_ovf", S_OVF, 0, (i >= 2) ? 1 : 0);
      push_exp("wrap_idle_ch1", S_COUNT, 1, 0);
      tick();
    end
    enable = '0; clear = 4'b0001;
    push_exp("wrap_clr_cnt", S_COUNT, 0, 0);
    push_exp("wrap_clr_ovf", S_OVF, 0, 0);
    tick();
    clear = '0; limit = '0; enable = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      push_exp("wrap0_cnt", S_COUNT, 0, 0);
      push_exp("wrap0_pulse", S_WRAP, 0, 1);
      push_exp("wrap0_ovf", S_OVF, 0, 1);
      tick();
    end
    enable = '0;
    push_exp("wrap0_stop", S_WRAP, 0, 0);
    tick();

    // SATURATE, limit 5 (mode change cycle first)
    mode = 2'd1; limit = 4'd5;
    push_exp("sat_mchg_cnt", S_COUNT, 0, 0);
    push_exp("sat_mchg_ovf", S_OVF, 0, 0);
    tick();
    enable = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      push_exp("sat_cnt", S_COUNT, 0, (i + 1 < 5) ? i + 1 : 5);
      push_exp("sat_ovf", S_OVF, 0, (i >= 4) ? 1 : 0);
      tick();
    end
    clear = 4'b0001;
    push_exp("sat_clr_cnt", S_COUNT, 0, 0);
    push_exp("sat_clr_ovf", S_OVF, 0, 0);
    tick();
    clear = '0;
    push_exp("sat_resume", S_COUNT, 0, 1);
    tick();
    limit = '0;
    push_exp("sat_low_cnt", S_COUNT, 0, 1);
    push_exp("sat_low_ovf", S_OVF, 0, 1);
    tick();
    enable = '0;
    push_exp("sat_hold_cnt", S_COUNT, 0, 1);
    tick();

    // RUN
    mode = 2'd2;
    push_exp("run_mchg_cnt", S_COUNT, 0, 0);
    push_exp("run_mchg_ovf", S_OVF, 0, 0);
    tick();
    enable = 4'b0010;
    for (int i = 0; i < 7; i++) begin
      push_exp("run_cnt", S_COUNT, 1, i + 1);
      push_exp("run_rv_low", S_RVALID, 1, 0);
      tick();
    end
    enable = '0;
    push_exp("run_len7", S_RUNLEN, 1, 7);
    push_exp("run_rv", S_RVALID, 1, 1);
    push_exp("run_cnt0", S_COUNT, 1, 0);
    tick();
    push_exp("run_rv_pulse", S_RVALID, 1, 0);
    push_exp("run_len_hold", S_RUNLEN, 1, 7);
    tick();
    enable = 4'b0010;
    push_exp("run1_cnt", S_COUNT, 1, 1);
    tick();
    enable = '0;
    push_exp("run_len1", S_RUNLEN, 1, 1);
    push_exp("run1_rv", S_RVALID, 1, 1);
    tick();

    // RUN saturation at 15
    enable = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      push_exp("rsat_cnt", S_COUNT, 0, (i + 1 < 15) ? i + 1 : 15);
      push_exp("rsat_ovf", S_OVF, 0, (i >= 14) ? 1 : 0);
      tick();
    end
    enable = '0;
    push_exp("rsat_len", S_RUNLEN, 0, 15);
    push_exp("rsat_rv", S_RVALID, 0, 1);
    push_exp("rsat_ovf_sticky", S_OVF, 0, 1);
    tick();

    // clear discards a run in progress
    enable = 4'b0010;
    repeat (3) tick();
    enable = '0; clear = 4'b0010;
    push_exp("rdisc_cnt", S_COUNT, 1, 0);
    push_exp("rdisc_rv", S_RVALID, 1, 0);
    push_exp("rdisc_len", S_RUNLEN, 1, 1);
    tick();

    // snapshot coherence
    clear = '1;
    tick();
    clear = '0;
    for (int k = 0; k < 4; k++) begin
      enable = (k >= 2) ? 4'b0111 : 4'b0101;
      tick();
    end
    snap = 1'b1; clear = 4'b0100; enable = 4'b0111;
    push_exp("snap_a", S_SNAP, 0, 4);
    push_exp("snap_a", S_SNAP, 1, 2);
    push_exp("snap_a", S_SNAP, 2, 4);
    push_exp("snap_a", S_SNAP, 3, 0);
    push_exp("snap_a_valid", S_SVALID, 0, 1);
    push_exp("snap_a_cnt", S_COUNT, 0, 5);
    push_exp("snap_a_cnt", S_COUNT, 2, 0);
    tick();
    clear = '0;
    push_exp("snap_b", S_SNAP, 0, 5);
    push_exp("snap_b", S_SNAP, 1, 3);
    push_exp("snap_b", S_SNAP, 2, 0);
    push_exp("snap_b_valid", S_SVALID, 0, 1);
    tick();
    snap = 1'b0;
    push_exp("snap_end_valid", S_SVALID, 0, 0);
    push_exp("snap_hold", S_SNAP, 0, 5);
    tick();

    // mode change mid-run, then reset mid-run
    mode = 2'd0; limit = 4'd9; enable = '0;
    push_all("mchg_cnt", S_COUNT, 0);
    push_all("mchg_rv", S_RVALID, 0);
    push_all("mchg_ovf", S_OVF, 0);
    tick();
    enable = 4'b0001;
    push_exp("mchg_resume", S_COUNT, 0, 1);
    tick();
    mode = 2'd2;
    push_exp("mchg2_cnt", S_COUNT, 0, 0);
    tick();
    repeat (2) tick();
    rst = 1'b1; enable = '0;
    push_all("rstrun_cnt", S_COUNT, 0);
    push_all("rstrun_rv", S_RVALID, 0);
    push_all("rstrun_wrap", S_WRAP, 0);
    push_all("rstrun_len", S_RUNLEN, 0);
    tick();
    rst = 1'b0;
    push_all("post_rst_rv", S_RVALID, 0);
    tick();
    enable = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      push_exp("post_rst_cnt", S_COUNT, 0, i + 1);
      tick();
    end
    enable = '0;
    push_exp("post_rst_len", S_RUNLEN, 0, 3);
    push_exp("post_rst_rv", S_RVALID, 0, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
